// File: rtl/crc_pkg.sv
// Shared CRC-8 definitions: polynomial, arbiter FSM states and the
// byte-wide parallel next-CRC function (poly 0x07, MSB first, no reflection).
package crc_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        RESULT = 2'd2
    } state_e;

    // Advance the CRC register by one data byte, MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_req_arbiter_if.sv
// Requester byte streams plus the single result port of the CRC arbiter.
// slave = the arbiter, master = the sources/consumer side.
interface crc_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      res_valid;
    logic                      res_ready;
    logic [7:0]                res_crc;
    logic [ID_W-1:0]           res_id;
    logic                      res_err;

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_crc, res_id, res_err
    );

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_crc, res_id, res_err
    );

endinterface

// File: rtl/crc8_step_comb.sv
// Combinational one-byte CRC-8 update; kept as its own module so the same
// datapath can be reused by the standalone parallel CRC block.
module crc8_step_comb
    import crc_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    assign crc_out = crc8_step(crc_in, data_in);

endmodule

// File: rtl/crc_req_arbiter.sv
// Round-robin frame arbiter in front of one CRC-8 datapath. A requester is
// granted for a whole frame; the frame CRC, owner id and timeout flag are
// presented on a valid/ready result port. All outputs come from flops.
module crc_req_arbiter
    import crc_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         DATA_W   = 8,
    parameter logic [7:0] CRC_INIT = 8'h00,
    parameter int         TIMEOUT  = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    crc_req_arbiter_if.slave   bus,
    output logic               busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int IDX_W = ID_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]         crc_q, crc_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [NUM_REQ-1:0] ready_q, ready_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_crc_q, res_crc_d;
    logic [ID_W-1:0]    res_id_q, res_id_d;
    logic               res_err_q, res_err_d;
    logic               busy_q, busy_d;

    logic [DATA_W-1:0]  data_arr [NUM_REQ];
    logic [7:0]         crc_nxt;
    logic               accept;
    logic               last_sel;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic [IDX_W-1:0]   idx_w;
    logic [ID_W-1:0]    rr_after_grant;

    // Split the flat data bus into one lane per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end

    crc8_step_comb u_crc (
        .crc_in  (crc_q),
        .data_in (data_arr[grant_q]),
        .crc_out (crc_nxt)
    );

    // ready_q is one-hot on the granted lane, so only that lane can accept.
    assign accept         = bus.req_valid[grant_q] & ready_q[grant_q];
    assign last_sel       = bus.req_last[grant_q];
    assign rr_after_grant = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        idx_w      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_w = {1'b0, rr_ptr_q} + IDX_W'(i);
            if (idx_w >= IDX_W'(NUM_REQ)) begin
                idx_w = idx_w - IDX_W'(NUM_REQ);
            end
            if (!pick_found && bus.req_valid[idx_w[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = idx_w[ID_W-1:0];
            end
        end
    end

    // Next-state and next-output logic of the grant/stream/result FSM.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        crc_d       = crc_q;
        idle_cnt_d  = idle_cnt_q;
        ready_d     = ready_q;
        res_valid_d = res_valid_q;
        res_crc_d   = res_crc_q;
        res_id_d    = res_id_q;
        res_err_d   = res_err_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    crc_d      = CRC_INIT;
                    idle_cnt_d = '0;
                    ready_d    = NUM_REQ'(1) << pick_id;
                    busy_d     = 1'b1;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    crc_d      = crc_nxt;
                    idle_cnt_d = '0;
                    if (last_sel) begin
                        ready_d     = '0;
                        res_valid_d = 1'b1;
                        res_crc_d   = crc_nxt;
                        res_id_d    = grant_q;
                        res_err_d   = 1'b0;
                        state_d     = RESULT;
                    end
                end else if (idle_cnt_q == CNT_LAST) begin
                    // Source went quiet too long: close the frame with what we have.
                    ready_d     = '0;
                    res_valid_d = 1'b1;
                    res_crc_d   = crc_q;
                    res_id_d    = grant_q;
                    res_err_d   = 1'b1;
                    state_d     = RESULT;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = rr_after_grant;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            crc_q       <= CRC_INIT;
            idle_cnt_q  <= '0;
            ready_q     <= '0;
            res_valid_q <= 1'b0;
            res_crc_q   <= 8'h00;
            res_id_q    <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            crc_q       <= crc_d;
            idle_cnt_q  <= idle_cnt_d;
            ready_q     <= ready_d;
            res_valid_q <= res_valid_d;
            res_crc_q   <= res_crc_d;
            res_id_q    <= res_id_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_crc   = res_crc_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_err   = res_err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_crc_req_arbiter.sv
// Bench for crc_req_arbiter: per-requester frame drivers, a frame-level
// round-robin reference model feeding an expected-result queue, and a
// monitor that checks every result handshake plus port-level rules.
module tb_crc_req_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    typedef struct { logic [7:0] data; bit last; int gap; } beat_t;
    typedef struct { logic [7:0] crc; int id; bit err; } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    crc_req_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(8)) bus ();

    crc_req_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (8),
        .CRC_INIT (8'h00),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    beat_t drv_q [NUM_REQ][$];
    res_t  frm_q [NUM_REQ][$];
    res_t  exp_q [$];
    int    gap_cnt [NUM_REQ];
    int    model_rr = 0;
    int    res_mode = 0;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference CRC: bit-serial long division, MSB first.
    function automatic logic [7:0] ref_crc(input logic [7:0] bytes[$]);
        logic [7:0] c;
        bit fb;
        c = 8'h00;
        foreach (bytes[k]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ bytes[k][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Queue a frame on requester r; exp_crc < 0 means use the reference CRC.
    task automatic add_frame(input int r, input logic [7:0] bytes[$], input bit abort,
                             input int max_gap, input int exp_crc);
        beat_t b;
        res_t  f;
        foreach (bytes[k]) begin
            b.data = bytes[k];
            b.last = !abort && (k == bytes.size() - 1);
            b.gap  = (k == 0) ? 0 : int'($urandom_range(0, max_gap));
            drv_q[r].push_back(b);
        end
        f.crc = (exp_crc < 0) ? ref_crc(bytes) : 8'(exp_crc);
        f.id  = r;
        f.err = abort;
        frm_q[r].push_back(f);
    endtask

    // Frame-level round robin: every requester with frames left is waiting
    // whenever the arbiter is free, so the order follows directly.
    task automatic schedule();
        bit any;
        int idx;
        do begin
            any = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = (model_rr + i) % NUM_REQ;
                if (!any && frm_q[idx].size() > 0) begin
                    exp_q.push_back(frm_q[idx].pop_front());
                    model_rr = (idx + 1) % NUM_REQ;
                    any = 1'b1;
                end
            end
        end while (any);
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() > 0);
        for (int i = 0; i < NUM_REQ; i++) if (drv_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_res_valid"}, bus.res_valid == 1'b0, 32'(bus.res_valid), 0);
        check({tag, "_req_ready"}, bus.req_ready == '0,  32'(bus.req_ready), 0);
        check({tag, "_res_crc"},   bus.res_crc == 8'h00, 32'(bus.res_crc),   0);
        check({tag, "_res_id"},    bus.res_id == '0,     32'(bus.res_id),    0);
        check({tag, "_res_err"},   bus.res_err == 1'b0,  32'(bus.res_err),   0);
        check({tag, "_busy"},      busy == 1'b0,         32'(busy),          0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        for (int i = 0; i < NUM_REQ; i++) begin
            drv_q[i].delete();
            frm_q[i].delete();
            gap_cnt[i] = 0;
        end
        exp_q.delete();
        model_rr = 0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, !pending(), 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        if (pending()) do_reset({name, "_recover"});
    endtask

    // Drivers: sample acceptance at negedge, update beats just after posedge.
    initial begin
        logic [NUM_REQ-1:0] acc;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) gap_cnt[i] = 0;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            if (!rst_n) acc = '0;
            if (res_mode == 1)      bus.res_ready = ($urandom_range(0, 3) != 0);
            else if (res_mode == 0) bus.res_ready = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] && drv_q[i].size() > 0) begin
                    void'(drv_q[i].pop_front());
                    gap_cnt[i] = 0;
                end
                if (drv_q[i].size() > 0 && gap_cnt[i] >= drv_q[i][0].gap) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_data[i*8 +: 8] = drv_q[i][0].data;
                    bus.req_last[i]        = drv_q[i][0].last;
                end else begin
                    bus.req_valid[i]       = 1'b0;
                    bus.req_data[i*8 +: 8] = 8'($urandom);
                    bus.req_last[i]        = 1'($urandom);
                    if (drv_q[i].size() > 0) gap_cnt[i]++;
                end
            end
        end
    end

    // Monitor: result scoreboard plus per-cycle port rules.
    initial begin
        bit         held;
        logic [7:0] h_crc;
        logic [1:0] h_id;
        bit         h_err;
        bit         last_acc;
        int         stall;
        res_t       e;
        held = 0; last_acc = 0; stall = 0; h_crc = 0; h_id = 0; h_err = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0; last_acc = 0; stall = 0;
                continue;
            end
            check("ready_onehot", $countones(bus.req_ready) <= 1, 32'(bus.req_ready), 0);
            if (bus.res_valid) begin
                check("ready_in_result", bus.req_ready == '0, 32'(bus.req_ready), 0);
                check("busy_in_result", busy == 1'b1, 32'(busy), 1);
            end
            if (last_acc)
                check("latency", bus.res_valid && !bus.res_err, 32'({bus.res_valid, bus.res_err}), 32'h2);
            if (held) begin
                check("hold_valid", bus.res_valid == 1'b1, 32'(bus.res_valid), 1);
                check("hold_crc", bus.res_crc == h_crc, 32'(bus.res_crc), 32'(h_crc));
                check("hold_id",  bus.res_id == h_id,   32'(bus.res_id),  32'(h_id));
                check("hold_err", bus.res_err == h_err, 32'(bus.res_err), 32'(h_err));
            end
            if (bus.res_valid && !held && bus.res_err)
                check("timeout_len", stall == TIMEOUT, 32'(stall), 32'(TIMEOUT));
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1'b0, 32'(bus.res_id), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("res_crc", bus.res_crc == e.crc,    32'(bus.res_crc), 32'(e.crc));
                    check("res_id",  bus.res_id == 2'(e.id),  32'(bus.res_id),  32'(e.id));
                    check("res_err", bus.res_err == e.err,    32'(bus.res_err), 32'(e.err));
                    $display("result id=%0d crc=0x%02h err=%0d", bus.res_id, bus.res_crc, bus.res_err);
                end
            end
            held     = bus.res_valid && !bus.res_ready;
            h_crc    = bus.res_crc;
            h_id     = bus.res_id;
            h_err    = bus.res_err;
            last_acc = |(bus.req_valid & bus.req_ready & bus.req_last);
            if (busy && !bus.res_valid && (bus.req_valid & bus.req_ready) == '0) stall++;
            else stall = 0;
        end
    end

    // Test sequence.
    initial begin
        logic [7:0] bq[$];
        int         n, nf, len;
        bit         ab;

        @(negedge clk);
        check_reset_outputs("reset");
        #2 rst_n = 1'b1;

        // 1: single 9-byte frame on req0, check value 0xF4
        bq.delete();
        for (int k = 0; k < 9; k++) bq.push_back(8'h31 + 8'(k));
        add_frame(0, bq, 1'b0, 0, 8'hF4);
        schedule();
        wait_done("t1_done", 200);

        // 2: req0 and req2 single-beat frames from reset
        do_reset("t2_reset");
        bq = {8'h01}; add_frame(0, bq, 1'b0, 0, 8'h07);
        bq = {8'h00}; add_frame(2, bq, 1'b0, 0, 8'h00);
        schedule();
        wait_done("t2_done", 200);

        // 3: all four busy with 1-beat frames -> 0,1,2,3,0,1
        do_reset("t3_reset");
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int f = 0; f < ((r < 2) ? 2 : 1); f++) begin
                bq = {8'($urandom)};
                add_frame(r, bq, 1'b0, 0, -1);
            end
        end
        schedule();
        wait_done("t3_done", 300);

        // 4: consumer stalls for 5 cycles
        res_mode = 2;
        bus.res_ready = 1'b0;
        bq = {8'hA5, 8'h5A};
        add_frame(3, bq, 1'b0, 0, -1);
        schedule();
        n = 0;
        while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
        check("t4_res_valid", bus.res_valid == 1'b1, 32'(bus.res_valid), 1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_idle_busy",  busy == 1'b0,          32'(busy),          0);
        check("t4_idle_valid", bus.res_valid == 1'b0, 32'(bus.res_valid), 0);
        res_mode = 0;
        wait_done("t4_done", 100);

        // 5: req1 sends two bytes then goes silent -> timeout result
        bq = {8'h31, 8'h32};
        add_frame(1, bq, 1'b1, 0, -1);
        schedule();
        wait_done("t5_done", 200);

        // 6: reset in the middle of a frame, then a clean frame
        bq.delete();
        for (int k = 0; k < 20; k++) bq.push_back(8'($urandom));
        add_frame(0, bq, 1'b0, 2, -1);
        schedule();
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); n++; end
        check("t6_busy", busy == 1'b1, 32'(busy), 1);
        repeat (4) @(negedge clk);
        do_reset("t6_reset");
        bq.delete();
        for (int k = 0; k < 9; k++) bq.push_back(8'h31 + 8'(k));
        add_frame(2, bq, 1'b0, 0, 8'hF4);
        schedule();
        wait_done("t6_done", 200);

        // Random frames, gaps, timeouts and consumer back-pressure.
        res_mode = 1;
        for (int round = 0; round < 6; round++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 6);
                    ab  = (f == nf - 1) && ($urandom_range(0, 3) == 0);
                    bq.delete();
                    for (int k = 0; k < len; k++) bq.push_back(8'($urandom));
                    add_frame(r, bq, ab, 3, -1);
                end
            end
            schedule();
            wait_done("rand_done", 4000);
        end
        res_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
